// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: opcodes, NOP encoding, data-memory sizing
// and the M-stage store-decode helper.
package mips_defs_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BE_W         = 4;
    localparam int unsigned DM_WORDS_DEF = 4096;
    localparam int unsigned DM_AW_DEF    = 12;

    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LBU = 6'b100100;

    localparam logic [WORD_W-1:0] NOP = 32'h0;

    // Byte-enable write request toward the data memory
    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] wdata;
    } dm_wr_t;

    // Alignment-checked store decode; data is replicated across lanes so the
    // byte enables alone select what lands in memory.
    function automatic dm_wr_t store_decode(input logic [5:0]        op,
                                            input logic [1:0]        boff,
                                            input logic [WORD_W-1:0] rt);
        dm_wr_t r;
        r = '0;
        case (op)
            OP_SW: begin
                if (boff == 2'b00) begin
                    r.we    = 1'b1;
                    r.be    = 4'b1111;
                    r.wdata = rt;
                end
            end
            OP_SH: begin
                if (!boff[0]) begin
                    r.we    = 1'b1;
                    r.be    = boff[1] ? 4'b1100 : 4'b0011;
                    r.wdata = {2{rt[15:0]}};
                end
            end
            OP_SB: begin
                r.we    = 1'b1;
                r.be    = 4'(4'b0001 << boff);
                r.wdata = {4{rt[7:0]}};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Data memory: synchronous whole-array clear, 4-lane byte-enable write port,
// combinational word read.
module dm_array
    import mips_defs_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEF,
    parameter int unsigned DM_AW    = DM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [DM_AW-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] mem [DM_WORDS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem[DM_AW'(i)] <= '0;
            end
        end else if (we) begin
            for (int unsigned k = 0; k < BE_W; k++) begin
                if (be[k]) begin
                    mem[addr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS M stage with M/W pipeline register: store decode into the data memory,
// raw aligned word read. Optional store trace enabled by DM_DISPLAY_EN.
module mem_stage
    import mips_defs_pkg::*;
#(
    parameter int unsigned DM_WORDS = DM_WORDS_DEF,
    parameter int unsigned DM_AW    = DM_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] IR_M,
    input  logic [WORD_W-1:0] AO_M,
    input  logic [WORD_W-1:0] RT_M,
    input  logic [WORD_W-1:0] pc4_M,
    input  logic [WORD_W-1:0] PC_M,
    output logic [WORD_W-1:0] IR_W,
    output logic [WORD_W-1:0] DR_W,
    output logic [WORD_W-1:0] AO_W,
    output logic [WORD_W-1:0] pc4_W
);

    logic              in_range_c;
    logic [DM_AW-1:0]  idx_c;
    dm_wr_t            dec_c;
    logic              wr_en_c;
    logic [WORD_W-1:0] rd_word_c;

    // Any address bit above the array's byte span puts the access out of range
    assign in_range_c = (AO_M[WORD_W-1:DM_AW+2] == '0);
    assign idx_c      = AO_M[DM_AW+1:2];
    assign dec_c      = store_decode(IR_M[31:26], AO_M[1:0], RT_M);
    assign wr_en_c    = dec_c.we & in_range_c;

    dm_array #(
        .DM_WORDS (DM_WORDS),
        .DM_AW    (DM_AW)
    ) u_dm (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en_c),
        .be      (dec_c.be),
        .addr    (idx_c),
        .wdata   (dec_c.wdata),
        .rdata_c (rd_word_c)
    );

    // M/W register; DR_W captures the pre-write word
    always_ff @(posedge clk) begin
        if (!reset) begin
            IR_W  <= NOP;
            DR_W  <= '0;
            AO_W  <= '0;
            pc4_W <= '0;
        end else begin
            IR_W  <= IR_M;
            DR_W  <= in_range_c ? rd_word_c : '0;
            AO_W  <= AO_M;
            pc4_W <= pc4_M;
        end
    end

`ifdef DM_DISPLAY_EN
    logic [WORD_W-1:0] merged_c;

    always_comb begin
        merged_c = rd_word_c;
        for (int unsigned k = 0; k < BE_W; k++) begin
            if (dec_c.be[k]) begin
                merged_c[8*k +: 8] = dec_c.wdata[8*k +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (reset && wr_en_c) begin
            $display("@%h: *%h <= %h", PC_M, {AO_M[31:2], 2'b00}, merged_c);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^PC_M;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed reference memory plus
// directed and randomized load/store traffic.
module tb_mem_stage;

    localparam int unsigned BYTES = 16384;
    localparam logic [31:0] I_SW = 32'hAC02_0000;
    localparam logic [31:0] I_SH = 32'hA402_0000;
    localparam logic [31:0] I_SB = 32'hA002_0000;
    localparam logic [31:0] I_LW = 32'h8C02_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, AO_M, RT_M, pc4_M, PC_M;
    logic [31:0] IR_W, DR_W, AO_W, pc4_W;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mb [BYTES];
    logic        exp_valid = 1'b0;
    logic [31:0] e_ir, e_dr, e_ao, e_pc4;

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .IR_M  (IR_M),
        .AO_M  (AO_M),
        .RT_M  (RT_M),
        .pc4_M (pc4_M),
        .PC_M  (PC_M),
        .IR_W  (IR_W),
        .DR_W  (DR_W),
        .AO_W  (AO_W),
        .pc4_W (pc4_W)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] ao);
        logic [31:0] a;
        if (ao >= BYTES) return 32'h0;
        a = ao & 32'hFFFF_FFFC;
        return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
    endfunction

    task automatic model_store(input logic [31:0] ir, input logic [31:0] ao, input logic [31:0] rt);
        logic [5:0] op;
        op = ir[31:26];
        if (ao >= BYTES) return;
        if (op == 6'b101011 && ao % 4 == 0) begin
            for (int i = 0; i < 4; i++) mb[ao+i] = 8'(rt >> (8*i));
        end else if (op == 6'b101001 && ao % 2 == 0) begin
            for (int i = 0; i < 2; i++) mb[ao+i] = 8'(rt >> (8*i));
        end else if (op == 6'b101000) begin
            mb[ao] = rt[7:0];
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] ir, input logic [31:0] ao,
                        input logic [31:0] rt, input logic [31:0] pc4);
        logic [31:0] n_ir, n_dr, n_ao, n_pc4;
        reset = rst;
        IR_M  = ir;
        AO_M  = ao;
        RT_M  = rt;
        pc4_M = pc4;
        PC_M  = pc4 - 32'd4;
        if (!rst) begin
            n_ir = 0; n_dr = 0; n_ao = 0; n_pc4 = 0;
            for (int i = 0; i < BYTES; i++) mb[i] = 8'h0;
        end else begin
            n_ir  = ir;
            n_dr  = model_read(ao);
            n_ao  = ao;
            n_pc4 = pc4;
            model_store(ir, ao, rt);
        end
        @(posedge clk);
        #1;
        e_ir = n_ir; e_dr = n_dr; e_ao = n_ao; e_pc4 = n_pc4;
        exp_valid = 1'b1;
    endtask

    // Per-cycle comparison against the reference model
    always @(negedge clk) begin
        if (exp_valid) begin
            check("IR_W", IR_W, e_ir);
            check("DR_W", DR_W, e_dr);
            check("AO_W", AO_W, e_ao);
            check("pc4_W", pc4_W, e_pc4);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] ir, ao;
        int          sel;
        ops[0] = 6'b101011; ops[1] = 6'b101001; ops[2] = 6'b101000; ops[3] = 6'b100011;
        ops[4] = 6'b100001; ops[5] = 6'b100000; ops[6] = 6'b000000; ops[7] = 6'b001000;

        // Reset overrides a pending store
        step(1'b0, I_SW, 32'h0, 32'h1234_5678, 32'h4);
        check("rst_IR_W", IR_W, 32'h0);
        check("rst_DR_W", DR_W, 32'h0);
        step(1'b1, I_LW, 32'h0, 32'h0, 32'h8);
        check("rst_lw0", DR_W, 32'h0);

        // Word store then load, with pc4 flowing one cycle later
        step(1'b1, I_SW, 32'h10, 32'hDEAD_BEEF, 32'h3004);
        check("pc4_3004", pc4_W, 32'h3004);
        step(1'b1, I_LW, 32'h10, 32'h0, 32'h3008);
        check("lw_word", DR_W, 32'hDEAD_BEEF);
        check("lw_ao", AO_W, 32'h10);
        check("lw_ir", IR_W, I_LW);
        check("pc4_3008", pc4_W, 32'h3008);

        // Byte and halfword merges
        step(1'b1, I_SB, 32'h13, 32'h0000_00AB, 32'h300C);
        step(1'b1, I_LW, 32'h10, 32'h0, 32'h3010);
        check("sb_merge", DR_W, 32'hABAD_BEEF);
        step(1'b1, I_SH, 32'h10, 32'h0000_1234, 32'h3014);
        step(1'b1, I_LW, 32'h10, 32'h0, 32'h3018);
        check("sh_merge", DR_W, 32'hABAD_1234);

        // Misaligned stores are dropped
        step(1'b1, I_SH, 32'h11, 32'hFFFF_FFFF, 32'h301C);
        step(1'b1, I_SW, 32'h12, 32'hFFFF_FFFF, 32'h3020);
        step(1'b1, I_LW, 32'h10, 32'h0, 32'h3024);
        check("misalign_keep", DR_W, 32'hABAD_1234);
        check("model_word10", model_read(32'h10), 32'hABAD_1234);

        // Out-of-range store and load
        step(1'b1, I_SW, 32'h4000, 32'h5555_5555, 32'h3028);
        step(1'b1, I_LW, 32'h0, 32'h0, 32'h302C);
        check("oor_no_alias", DR_W, 32'h0);
        step(1'b1, I_LW, 32'h4000, 32'h0, 32'h3030);
        check("oor_read0", DR_W, 32'h0);

        // Top word of the array is reachable
        step(1'b1, I_SW, 32'h3FFC, 32'hCAFE_F00D, 32'h3034);
        step(1'b1, I_LW, 32'h3FFC, 32'h0, 32'h3038);
        check("top_word", DR_W, 32'hCAFE_F00D);

        // Randomized traffic over a small window plus edge/out-of-range addresses
        for (int n = 0; n < 800; n++) begin
            ir  = {ops[$urandom_range(0, 7)], 26'($urandom)};
            sel = $urandom_range(0, 9);
            if (sel == 0)      ao = $urandom | 32'h0000_4000;
            else if (sel == 1) ao = 32'h3FF8 + 32'($urandom_range(0, 7));
            else               ao = 32'($urandom_range(0, 63));
            step(($urandom_range(0, 99) != 0), ir, ao, $urandom, $urandom);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
